// File: rtl/alu_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared definitions for the ALU arbiter and its ALU.
//   - ALU opcode width and opcode encodings
//   - requester id type (one bit: 0 = r0, 1 = r1)
//   - response buffer state enum
//   - helper that flags the two unused opcodes (110, 111)
// ----------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int ALUOP_W = 3;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_SRL = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_SRA = 3'b101;

    typedef logic req_id_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    function automatic logic is_illegal_op(input logic [ALUOP_W-1:0] op);
        return (op[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// ----------------------------------------------------------------------------
// alu
//   Purely combinational 32-bit ALU shared by the arbiter's requesters.
//   Ports:
//     a      in  32  operand A
//     b      in  32  operand B / shift amount (all 32 bits are significant)
//     op     in  3   opcode: add, sub, and, or, srl, sra
//     result out 32  result (0 for the unused opcodes)
// ----------------------------------------------------------------------------
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    input  logic [ALUOP_W-1:0] op,
    output logic [31:0]        result
);

    // A shift distance of 32 or more pushes every bit out of the word.
    logic shift_all;
    assign shift_all = |b[31:5];

    always_comb begin
        // NOTE: a default before the case means every path assigns result,
        // so no latch is inferred for the unused opcodes.
        result = '0;
        case (op)
            ALUOP_ADD: result = a + b;
            ALUOP_SUB: result = a - b;
            ALUOP_AND: result = a & b;
            ALUOP_OR:  result = a | b;
            ALUOP_SRL: result = shift_all ? '0 : (a >> b[4:0]);
            ALUOP_SRA: result = shift_all ? {32{a[31]}}
                                          : 32'($signed(a) >>> b[4:0]);
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one combinational alu between two requesters (r0: EX stage,
//   r1: secondary unit). One request is granted per cycle, evaluated on the
//   ALU and captured in a one-entry response buffer owned by the winner.
//
//   Parameter PRIO_MODE: 0 = round-robin on ties, 1 = r0 always wins ties.
//
//   Ports (N = 0,1):
//     clk             in   clock, rising edge
//     reset           in   synchronous active-high reset
//     rN_valid        in   request valid
//     rN_ready        out  request accepted this cycle
//     rN_a, rN_b      in   operands (32 bits)
//     rN_op           in   ALU opcode (3 bits); 110/111 are illegal
//     rN_rsp_valid    out  response valid for requester N
//     rN_rsp_data     out  result (32 bits)
//     rN_rsp_err      out  illegal opcode flag
//     rN_rsp_ready    in   requester consumes its response
//
//   Optional macro ALU_ARBITER_PERF_EN adds 32-bit wrapping counters:
//     perf_grant0/perf_grant1  transfers per requester
//     perf_conflict            cycles with both valid while a request
//                              can be accepted
// ----------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
`ifdef ALU_ARBITER_PERF_EN
    output logic [31:0]        perf_grant0,
    output logic [31:0]        perf_grant1,
    output logic [31:0]        perf_conflict,
`endif
    input  logic               r0_valid,
    output logic               r0_ready,
    input  logic [31:0]        r0_a,
    input  logic [31:0]        r0_b,
    input  logic [ALUOP_W-1:0] r0_op,
    output logic               r0_rsp_valid,
    output logic [31:0]        r0_rsp_data,
    output logic               r0_rsp_err,
    input  logic               r0_rsp_ready,
    input  logic               r1_valid,
    output logic               r1_ready,
    input  logic [31:0]        r1_a,
    input  logic [31:0]        r1_b,
    input  logic [ALUOP_W-1:0] r1_op,
    output logic               r1_rsp_valid,
    output logic [31:0]        r1_rsp_data,
    output logic               r1_rsp_err,
    input  logic               r1_rsp_ready
);

    buf_state_t         state_q, state_d;
    req_id_t            owner_q;
    req_id_t            last_grant_q;
    logic [31:0]        data_q;
    logic               err_q;

    req_id_t            grant;
    logic               owner_rsp_ready;
    logic               can_accept;
    logic               transfer;
    logic               both_valid;
    logic [31:0]        alu_a, alu_b, alu_result;
    logic [ALUOP_W-1:0] alu_op;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign both_valid      = r0_valid && r1_valid;
    assign owner_rsp_ready = (owner_q == 1'b1) ? r1_rsp_ready : r0_rsp_ready;
    // Gating with reset keeps requests in the reset cycle from being taken.
    assign can_accept      = !reset && ((state_q == EMPTY) || owner_rsp_ready);

    always_comb begin
        grant = 1'b0;
        if (both_valid) begin
            grant = (PRIO_MODE == 1) ? 1'b0 : ~last_grant_q;
        end else if (r1_valid) begin
            grant = 1'b1;
        end
    end

    assign r0_ready = can_accept && (grant == 1'b0);
    assign r1_ready = can_accept && (grant == 1'b1);
    assign transfer = (r0_valid && r0_ready) || (r1_valid && r1_ready);

    // The granted requester's operands are the only path into the ALU.
    assign alu_a  = grant ? r1_a  : r0_a;
    assign alu_b  = grant ? r1_b  : r0_b;
    assign alu_op = grant ? r1_op : r0_op;

    alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result)
    );

    // ------------------------------------------------------------------
    // Response buffer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (transfer) state_d = FULL;
            FULL:  if (!transfer && owner_rsp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q      <= EMPTY;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (transfer) begin
                owner_q      <= grant;
                last_grant_q <= grant;
                err_q        <= is_illegal_op(alu_op);
                data_q       <= is_illegal_op(alu_op) ? '0 : alu_result;
            end
        end
    end

    // Only the owner sees the buffered result; the other side reads zeros.
    assign r0_rsp_valid = (state_q == FULL) && (owner_q == 1'b0);
    assign r1_rsp_valid = (state_q == FULL) && (owner_q == 1'b1);
    assign r0_rsp_data  = r0_rsp_valid ? data_q : '0;
    assign r1_rsp_data  = r1_rsp_valid ? data_q : '0;
    assign r0_rsp_err   = r0_rsp_valid && err_q;
    assign r1_rsp_err   = r1_rsp_valid && err_q;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef ALU_ARBITER_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_grant0   <= '0;
            perf_grant1   <= '0;
            perf_conflict <= '0;
        end else begin
            if (r0_valid && r0_ready) perf_grant0 <= perf_grant0 + 32'd1;
            if (r1_valid && r1_ready) perf_grant1 <= perf_grant1 + 32'd1;
            if (both_valid && can_accept) perf_conflict <= perf_conflict + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed scenarios followed by randomized traffic for alu_arbiter.
//   A transaction-level model (pending response slot, last winner, counters)
//   predicts ready, response and counter values every cycle. A second
//   instance with PRIO_MODE=1 shares the stimulus for the fixed-priority case.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [2:0]  r0_op = '0, r1_op = '0;
    logic        r0_rsp_ready = 1'b0, r1_rsp_ready = 1'b0;

    logic        r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid;
    logic        r0_rsp_err, r1_rsp_err;
    logic [31:0] r0_rsp_data, r1_rsp_data;

    logic        p1_r0_ready, p1_r1_ready, p1_r0_rsp_valid, p1_r1_rsp_valid;
    logic        p1_r0_rsp_err, p1_r1_rsp_err;
    logic [31:0] p1_r0_rsp_data, p1_r1_rsp_data;

`ifdef ALU_ARBITER_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_conflict;
    logic [31:0] p1_perf_grant0, p1_perf_grant1, p1_perf_conflict;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(.PRIO_MODE(0)) u_dut (
        .clk(clk), .reset(reset),
`ifdef ALU_ARBITER_PERF_EN
        .perf_grant0(perf_grant0), .perf_grant1(perf_grant1),
        .perf_conflict(perf_conflict),
`endif
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_op(r0_op), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_data(r0_rsp_data),
        .r0_rsp_err(r0_rsp_err), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_op(r1_op), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_data(r1_rsp_data),
        .r1_rsp_err(r1_rsp_err), .r1_rsp_ready(r1_rsp_ready)
    );

    alu_arbiter #(.PRIO_MODE(1)) u_dut_p1 (
        .clk(clk), .reset(reset),
`ifdef ALU_ARBITER_PERF_EN
        .perf_grant0(p1_perf_grant0), .perf_grant1(p1_perf_grant1),
        .perf_conflict(p1_perf_conflict),
`endif
        .r0_valid(r0_valid), .r0_ready(p1_r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_op(r0_op), .r0_rsp_valid(p1_r0_rsp_valid), .r0_rsp_data(p1_r0_rsp_data),
        .r0_rsp_err(p1_r0_rsp_err), .r0_rsp_ready(r0_rsp_ready),
        .r1_valid(r1_valid), .r1_ready(p1_r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_op(r1_op), .r1_rsp_valid(p1_r1_rsp_valid), .r1_rsp_data(p1_r1_rsp_data),
        .r1_rsp_err(p1_r1_rsp_err), .r1_rsp_ready(r1_rsp_ready)
    );

    int n_compared = 0;
    int n_mismatched = 0;

    // Reference model of the PRIO_MODE=0 instance, kept at transaction level.
    bit          m_pending = 0;   // a response is waiting for its owner
    int          m_owner   = 0;   // which requester owns it
    logic [31:0] m_data    = '0;
    bit          m_err     = 0;
    int          m_last    = 1;   // last winner; 1 lets r0 win the first tie
    int          m_g0 = 0, m_g1 = 0, m_conf = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Result of one operation from the opcode table; {err, data}.
    function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            3'd0: return {1'b0, a + b};
            3'd1: return {1'b0, a - b};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a >> b};
            3'd5: return {1'b0, 32'($signed(a) >>> b)};
            default: return {1'b1, 32'd0};
        endcase
    endfunction

    task automatic drive(input bit v0, input logic [2:0] op0, input logic [31:0] a0,
                         input logic [31:0] b0, input bit v1, input logic [2:0] op1,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input bit rr0, input bit rr1);
        r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
        r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
        r0_rsp_ready = rr0; r1_rsp_ready = rr1;
    endtask

    // One clock: predict and check ready, clock, update model, check responses.
    task automatic tick();
        bit          owner_takes, can, winner, xfer;
        logic [32:0] res;
        #1;
        owner_takes = (m_owner == 1) ? r1_rsp_ready : r0_rsp_ready;
        can = !reset && (!m_pending || owner_takes);
        if (r0_valid && r1_valid) winner = (m_last == 0);
        else                      winner = r1_valid;
        if (r0_valid) check("r0_ready", {31'd0, r0_ready}, {31'd0, can && !winner});
        if (r1_valid) check("r1_ready", {31'd0, r1_ready}, {31'd0, can && winner});
        xfer = can && (r0_valid || r1_valid);
        res  = winner ? ref_op(r1_op, r1_a, r1_b) : ref_op(r0_op, r0_a, r0_b);
        @(posedge clk);
        #1;
        if (reset) begin
            m_pending = 0; m_last = 1; m_g0 = 0; m_g1 = 0; m_conf = 0;
        end else begin
            if (r0_valid && r1_valid && can) m_conf++;
            if (xfer) begin
                m_pending = 1; m_owner = winner; m_last = winner;
                m_err = res[32]; m_data = res[31:0];
                if (winner) m_g1++; else m_g0++;
            end else if (m_pending && owner_takes) begin
                m_pending = 0;
            end
        end
        check("r0_rsp_valid", {31'd0, r0_rsp_valid}, {31'd0, m_pending && m_owner == 0});
        check("r1_rsp_valid", {31'd0, r1_rsp_valid}, {31'd0, m_pending && m_owner == 1});
        check("r0_rsp_data", r0_rsp_data, (m_pending && m_owner == 0) ? m_data : 32'd0);
        check("r1_rsp_data", r1_rsp_data, (m_pending && m_owner == 1) ? m_data : 32'd0);
        check("r0_rsp_err", {31'd0, r0_rsp_err}, {31'd0, m_pending && m_owner == 0 && m_err});
        check("r1_rsp_err", {31'd0, r1_rsp_err}, {31'd0, m_pending && m_owner == 1 && m_err});
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
        check("rst_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);

        // 1. r0 only, add 5+3
        drive(1, ALUOP_ADD, 5, 3, 0, 0, 0, 0, 1, 1);
        tick();
        check("t1_data", r0_rsp_data, 32'd8);
        check("t1_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        tick();

        // 2. both valid every cycle: round-robin on u_dut, r0 always on u_dut_p1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, ALUOP_SUB, 10, 3, 1, ALUOP_AND, 32'hF0, 32'h3C, 1, 1);
            #1;
            check("t2_p1_r0_ready", {31'd0, p1_r0_ready}, 32'd1);
            check("t2_p1_r1_ready", {31'd0, p1_r1_ready}, 32'd0);
            tick();
            if (i % 2 == 0) check("t2_r0_data", r0_rsp_data, 32'd7);
            else            check("t2_r1_data", r1_rsp_data, 32'h30);
        end

        // 3. r0 response stalled, r1 waits, then is accepted on release
        do_reset();
        drive(1, ALUOP_ADD, 1, 2, 0, 0, 0, 0, 0, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, ALUOP_OR, 32'hC, 32'h3, 0, 1);
            #1;
            check("t3_r1_blocked", {31'd0, r1_ready}, 32'd0);
            tick();
            check("t3_r0_held", r0_rsp_data, 32'd3);
        end
        drive(0, 0, 0, 0, 1, ALUOP_OR, 32'hC, 32'h3, 1, 1);
        #1;
        check("t3_r1_accept", {31'd0, r1_ready}, 32'd1);
        tick();
        check("t3_r1_rsp", r1_rsp_data, 32'hF);

        // 4. boundary operations
        drive(1, ALUOP_SRA, 32'h8000_0000, 4, 0, 0, 0, 0, 1, 1);
        tick(); check("t4_sra4", r0_rsp_data, 32'hF800_0000);
        drive(1, ALUOP_SRL, 32'hFFFF_FFFF, 32, 0, 0, 0, 0, 1, 1);
        tick(); check("t4_srl32", r0_rsp_data, 32'd0);
        drive(1, ALUOP_SRA, 32'h8000_0000, 40, 0, 0, 0, 0, 1, 1);
        tick(); check("t4_sra40", r0_rsp_data, 32'hFFFF_FFFF);
        drive(1, 3'b110, 32'h1234, 32'h1, 0, 0, 0, 0, 1, 1);
        tick();
        check("t4_ill_err", {31'd0, r0_rsp_err}, 32'd1);
        check("t4_ill_data", r0_rsp_data, 32'd0);

        // 5. reset while FULL
        drive(1, ALUOP_ADD, 7, 7, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        drive(1, ALUOP_ADD, 1, 1, 1, ALUOP_ADD, 2, 2, 0, 0);
        tick();
        check("t5_r0_rsp_valid", {31'd0, r0_rsp_valid}, 32'd0);
        check("t5_r1_rsp_valid", {31'd0, r1_rsp_valid}, 32'd0);
        reset = 1'b0;
        tick();
        check("t5_r0_first", {31'd0, r0_rsp_valid}, 32'd1);

`ifdef ALU_ARBITER_PERF_EN
        // 6. counters over 10 contended cycles, then reset
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, ALUOP_ADD, i, 1, 1, ALUOP_SUB, i, 1, 1, 1);
            tick();
        end
        check("t6_conflict", perf_conflict, 32'd10);
        check("t6_grant0", perf_grant0, 32'd5);
        check("t6_grant1", perf_grant1, 32'd5);
        do_reset();
        check("t6_rst_conflict", perf_conflict, 32'd0);
        check("t6_rst_grant0", perf_grant0, 32'd0);
        check("t6_rst_grant1", perf_grant1, 32'd0);
`endif

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] b0, b1;
            b0 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            b1 = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, b0,
                  $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, b1,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 49) == 0);
            tick();
`ifdef ALU_ARBITER_PERF_EN
            check("rnd_grant0", perf_grant0, m_g0);
            check("rnd_grant1", perf_grant1, m_g1);
            check("rnd_conflict", perf_conflict, m_conf);
`endif
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
